// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic light controller and its configuration master.
package tlc_pkg;

  localparam int TLC_ADDR_RED    = 0;
  localparam int TLC_ADDR_YELLOW = 1;
  localparam int TLC_ADDR_GREEN  = 2;

  localparam int CFG_NUM_WRITES = 3;

  typedef enum logic [1:0] {
    LIGHT_RED    = 2'd0,
    LIGHT_YELLOW = 2'd1,
    LIGHT_GREEN  = 2'd2
  } tlc_light_e;

  typedef enum logic [2:0] {
    CFG_IDLE  = 3'd0,
    CFG_REQ   = 3'd1,
    CFG_GAP   = 3'd2,
    CFG_FIN   = 3'd3,
    CFG_ABORT = 3'd4
  } cfg_state_e;

endpackage

// File: rtl/tlc_wdog.sv
// Per-handshake watchdog: counts waiting cycles and flags the cycle that would
// reach TIMEOUT, so the master can abort on exactly that edge.
module tlc_wdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Saturates at TIMEOUT so a stalled count never wraps back to a small value.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (count && (cnt != CW'(TIMEOUT))) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/tlc_cfg_master.sv
// Programs the red/yellow/green duration registers of the traffic light
// controller with three handshaked writes, each guarded by a timeout.
module tlc_cfg_master
  import tlc_pkg::*;
#(
  parameter int ADDR_WIDTH  = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_RED    = TLC_ADDR_RED,
  parameter int ADDR_YELLOW = TLC_ADDR_YELLOW,
  parameter int ADDR_GREEN  = TLC_ADDR_GREEN,
  parameter int TIMEOUT     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] t_red,
  input  logic [DATA_WIDTH-1:0] t_yellow,
  input  logic [DATA_WIDTH-1:0] t_green,
  input  logic                  ready,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] err_addr
);

  cfg_state_e state, state_n;

  logic [1:0]            idx, idx_n;
  logic [DATA_WIDTH-1:0] sh_red, sh_yellow, sh_green;
  logic [DATA_WIDTH-1:0] next_shadow;
  logic [ADDR_WIDTH-1:0] addr_n, err_addr_n;
  logic [DATA_WIDTH-1:0] data_n;
  logic                  valid_n, busy_n, done_n, error_n;
  logic                  wd_clear, wd_count, wd_expired;

  function automatic logic [ADDR_WIDTH-1:0] wr_addr(input logic [1:0] i);
    case (i)
      2'd0:    return ADDR_WIDTH'(ADDR_RED);
      2'd1:    return ADDR_WIDTH'(ADDR_YELLOW);
      default: return ADDR_WIDTH'(ADDR_GREEN);
    endcase
  endfunction

  // Durations are frozen at start so the host may change its inputs mid-sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_red    <= '0;
      sh_yellow <= '0;
      sh_green  <= '0;
    end else if (state == CFG_IDLE && start) begin
      sh_red    <= t_red;
      sh_yellow <= t_yellow;
      sh_green  <= t_green;
    end
  end

  always_comb begin
    next_shadow = sh_green;
    case (idx)
      2'd0:    next_shadow = sh_yellow;
      default: next_shadow = sh_green;
    endcase
  end

  // Outputs are registered; done is a default-low pulse raised on entry to FIN/ABORT.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    valid_n    = valid;
    addr_n     = addr;
    data_n     = data;
    busy_n     = busy;
    done_n     = 1'b0;
    error_n    = error;
    err_addr_n = err_addr;
    wd_count   = 1'b0;

    case (state)
      CFG_IDLE: begin
        if (start) begin
          state_n = CFG_REQ;
          idx_n   = 2'd0;
          valid_n = 1'b1;
          addr_n  = wr_addr(2'd0);
          data_n  = t_red;
          busy_n  = 1'b1;
          error_n = 1'b0;
        end
      end

      CFG_REQ: begin
        if (ready) begin
          state_n = CFG_GAP;
          valid_n = 1'b0;
        end else if (wd_expired) begin
          state_n    = CFG_ABORT;
          valid_n    = 1'b0;
          error_n    = 1'b1;
          err_addr_n = addr;
          done_n     = 1'b1;
          busy_n     = 1'b0;
        end else begin
          wd_count = 1'b1;
        end
      end

      // Waiting for ready to drop keeps the previous acknowledge from being reused.
      CFG_GAP: begin
        if (!ready) begin
          if (idx == 2'd2) begin
            state_n = CFG_FIN;
            done_n  = 1'b1;
            busy_n  = 1'b0;
          end else begin
            state_n = CFG_REQ;
            idx_n   = idx + 2'd1;
            valid_n = 1'b1;
            addr_n  = wr_addr(idx + 2'd1);
            data_n  = next_shadow;
          end
        end else if (wd_expired) begin
          state_n    = CFG_ABORT;
          error_n    = 1'b1;
          err_addr_n = addr;
          done_n     = 1'b1;
          busy_n     = 1'b0;
        end else begin
          wd_count = 1'b1;
        end
      end

      CFG_FIN:   state_n = CFG_IDLE;
      CFG_ABORT: state_n = CFG_IDLE;
      default:   state_n = CFG_IDLE;
    endcase
  end

  assign wd_clear = (state_n != state);

  tlc_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .count   (wd_count),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CFG_IDLE;
      idx      <= 2'd0;
      valid    <= 1'b0;
      addr     <= '0;
      data     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_addr <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      valid    <= valid_n;
      addr     <= addr_n;
      data     <= data_n;
      busy     <= busy_n;
      done     <= done_n;
      error    <= error_n;
      err_addr <= err_addr_n;
    end
  end

endmodule

// File: tb/tb_tlc_cfg_master.sv
// Scoreboard bench for tlc_cfg_master against a behavioural register-write responder.
module tb_tlc_cfg_master;
  import tlc_pkg::*;

  localparam int AW = 3;
  localparam int DW = 8;
  localparam int TO = 16;

  typedef enum {M_NORMAL, M_STALL, M_STUCK} mode_e;
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] t_red, t_yellow, t_green;
  logic          ready;
  logic [AW-1:0] addr, err_addr;
  logic [DW-1:0] data;
  logic          valid, busy, done, error;

  mode_e         mode;
  logic [DW-1:0] regs [0:7];
  wr_t           exp_q[$];
  wr_t           obs_q[$];
  int            rd_ptr = 0;
  int            valid_cycles = 0;
  int            done_pulses = 0;
  int            compared = 0;
  int            mismatched = 0;

  tlc_cfg_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_RED(0), .ADDR_YELLOW(1),
    .ADDR_GREEN(2), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .t_red(t_red), .t_yellow(t_yellow),
    .t_green(t_green), .ready(ready), .addr(addr), .data(data), .valid(valid),
    .busy(busy), .done(done), .error(error), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  // Responder: registers ready one cycle after valid, commits on handshake.
  always @(posedge clk) begin
    if (rst) begin
      ready <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (valid && ready) regs[addr] <= data;
      case (mode)
        M_NORMAL: ready <= valid && !ready;
        M_STALL:  ready <= 1'b0;
        default:  ready <= ready || valid;
      endcase
    end
  end

  // Observer: records each handshake seen mid-cycle.
  always @(negedge clk) begin
    if (!rst && valid && ready) obs_q.push_back({addr, data});
    if (valid) valid_cycles++;
    if (done) done_pulses++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic pulse_start(input logic [DW-1:0] r, input logic [DW-1:0] y,
                             input logic [DW-1:0] g);
    @(negedge clk);
    t_red = r; t_yellow = y; t_green = g;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cycles);
    cycles = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = M_NORMAL;
    t_red = '0; t_yellow = '0; t_green = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compared++; if (valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %b, want 0", valid); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b, want 0", busy); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b, want 0", done); end
    compared++; if (error !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_error: got %b, want 0", error); end
    compared++; if (addr !== '0) begin mismatched++; $display("[TB] FAIL reset_addr: got %0d, want 0", addr); end
    compared++; if (data !== '0) begin mismatched++; $display("[TB] FAIL reset_data: got %0d, want 0", data); end
    compared++; if (err_addr !== '0) begin mismatched++; $display("[TB] FAIL reset_err_addr: got %0d, want 0", err_addr); end
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    int  cyc;
    wr_t e, o;
    exp_q.push_back({3'd0, 8'd5});
    exp_q.push_back({3'd1, 8'd2});
    exp_q.push_back({3'd2, 8'd4});
    pulse_start(8'd5, 8'd2, 8'd4);
    wait_done(100, cyc);
    compared++; if (cyc !== 10) begin mismatched++; $display("[TB] FAIL nominal_latency: got %0d cycles, want 10", cyc); end
    compared++; if (error !== 1'b0) begin mismatched++; $display("[TB] FAIL nominal_error: got %b, want 0", error); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL nominal_busy_at_done: got %b, want 0", busy); end
    @(negedge clk);
    compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL nominal_done_pulse: got %b one cycle later, want 0", done); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (rd_ptr >= obs_q.size()) begin
        mismatched++; $display("[TB] FAIL nominal_write: got no handshake, want addr=%0d data=%0d", e.a, e.d);
      end else begin
        o = obs_q[rd_ptr]; rd_ptr++;
        if (o !== e) begin mismatched++; $display("[TB] FAIL nominal_write: got addr=%0d data=%0d, want addr=%0d data=%0d", o.a, o.d, e.a, e.d); end
      end
    end
    compared++; if (obs_q.size() != rd_ptr) begin mismatched++; $display("[TB] FAIL nominal_extra_writes: got %0d extra, want 0", obs_q.size() - rd_ptr); end
    rd_ptr = obs_q.size();
    compared++; if ({regs[0], regs[1], regs[2]} !== {8'd5, 8'd2, 8'd4}) begin
      mismatched++; $display("[TB] FAIL nominal_regs: got %0d/%0d/%0d, want 5/2/4", regs[0], regs[1], regs[2]);
    end
  endtask

  task automatic test_stall();
    int cyc, v0;
    mode = M_STALL;
    v0 = valid_cycles;
    pulse_start(8'd7, 8'd3, 8'd1);
    wait_done(100, cyc);
    compared++; if (cyc !== TO + 1) begin mismatched++; $display("[TB] FAIL stall_latency: got %0d cycles, want %0d", cyc, TO + 1); end
    compared++; if (error !== 1'b1) begin mismatched++; $display("[TB] FAIL stall_error: got %b, want 1", error); end
    compared++; if (err_addr !== 3'd0) begin mismatched++; $display("[TB] FAIL stall_err_addr: got %0d, want 0", err_addr); end
    compared++; if (valid_cycles - v0 !== TO) begin mismatched++; $display("[TB] FAIL stall_valid_time: got %0d cycles, want %0d", valid_cycles - v0, TO); end
    compared++; if (obs_q.size() != rd_ptr) begin mismatched++; $display("[TB] FAIL stall_no_write: got %0d writes, want 0", obs_q.size() - rd_ptr); end
    rd_ptr = obs_q.size();
    mode = M_NORMAL;
  endtask

  task automatic test_stuck_ready();
    int  cyc;
    wr_t e, o;
    mode = M_STUCK;
    exp_q.push_back({3'd0, 8'd9});
    pulse_start(8'd9, 8'd8, 8'd7);
    wait_done(100, cyc);
    compared++; if (cyc !== TO + 3) begin mismatched++; $display("[TB] FAIL stuck_latency: got %0d cycles, want %0d", cyc, TO + 3); end
    compared++; if (error !== 1'b1) begin mismatched++; $display("[TB] FAIL stuck_error: got %b, want 1", error); end
    compared++; if (err_addr !== 3'd0) begin mismatched++; $display("[TB] FAIL stuck_err_addr: got %0d, want 0", err_addr); end
    e = exp_q.pop_front();
    compared++;
    if (rd_ptr >= obs_q.size()) begin
      mismatched++; $display("[TB] FAIL stuck_first_write: got no handshake, want addr=%0d data=%0d", e.a, e.d);
    end else begin
      o = obs_q[rd_ptr]; rd_ptr++;
      if (o !== e) begin mismatched++; $display("[TB] FAIL stuck_first_write: got addr=%0d data=%0d, want addr=%0d data=%0d", o.a, o.d, e.a, e.d); end
    end
    mode = M_NORMAL;
    repeat (3) @(negedge clk);
    compared++; if (obs_q.size() != rd_ptr) begin mismatched++; $display("[TB] FAIL stuck_second_write: got %0d extra writes, want 0", obs_q.size() - rd_ptr); end
    rd_ptr = obs_q.size();
  endtask

  task automatic test_back_to_back();
    int  cyc;
    wr_t e, o;
    exp_q.push_back({3'd0, 8'd11});
    exp_q.push_back({3'd1, 8'd12});
    exp_q.push_back({3'd2, 8'd13});
    pulse_start(8'd11, 8'd12, 8'd13);
    @(negedge clk);
    compared++; if (error !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_error_cleared: got %b, want 0", error); end
    wait_done(100, cyc);
    compared++; if (cyc !== 9) begin mismatched++; $display("[TB] FAIL b2b_first_latency: got %0d cycles, want 9", cyc); end
    exp_q.push_back({3'd0, 8'd21});
    exp_q.push_back({3'd1, 8'd22});
    exp_q.push_back({3'd2, 8'd23});
    pulse_start(8'd21, 8'd22, 8'd23);
    wait_done(100, cyc);
    compared++; if (cyc !== 10) begin mismatched++; $display("[TB] FAIL b2b_second_latency: got %0d cycles, want 10", cyc); end
    compared++; if (error !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_error: got %b, want 0", error); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (rd_ptr >= obs_q.size()) begin
        mismatched++; $display("[TB] FAIL b2b_write: got no handshake, want addr=%0d data=%0d", e.a, e.d);
      end else begin
        o = obs_q[rd_ptr]; rd_ptr++;
        if (o !== e) begin mismatched++; $display("[TB] FAIL b2b_write: got addr=%0d data=%0d, want addr=%0d data=%0d", o.a, o.d, e.a, e.d); end
      end
    end
    compared++; if ({regs[0], regs[1], regs[2]} !== {8'd21, 8'd22, 8'd23}) begin
      mismatched++; $display("[TB] FAIL b2b_regs: got %0d/%0d/%0d, want 21/22/23", regs[0], regs[1], regs[2]);
    end
    rd_ptr = obs_q.size();
  endtask

  task automatic test_input_change();
    int  cyc, v0;
    wr_t e, o;
    exp_q.push_back({3'd0, 8'd5});
    exp_q.push_back({3'd1, 8'd2});
    exp_q.push_back({3'd2, 8'd4});
    pulse_start(8'd5, 8'd2, 8'd4);
    t_red = 8'd9; t_yellow = 8'd9; t_green = 8'd9;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(100, cyc);
    compared++; if (cyc !== 5) begin mismatched++; $display("[TB] FAIL change_latency: got %0d remaining cycles, want 5", cyc); end
    @(negedge clk);
    v0 = valid_cycles;
    repeat (15) @(negedge clk);
    compared++; if (valid_cycles !== v0 || busy !== 1'b0) begin
      mismatched++; $display("[TB] FAIL change_no_second_run: got %0d valid cycles busy=%b, want 0 busy=0", valid_cycles - v0, busy);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (rd_ptr >= obs_q.size()) begin
        mismatched++; $display("[TB] FAIL change_write: got no handshake, want addr=%0d data=%0d", e.a, e.d);
      end else begin
        o = obs_q[rd_ptr]; rd_ptr++;
        if (o !== e) begin mismatched++; $display("[TB] FAIL change_write: got addr=%0d data=%0d, want addr=%0d data=%0d", o.a, o.d, e.a, e.d); end
      end
    end
    compared++; if (obs_q.size() != rd_ptr) begin mismatched++; $display("[TB] FAIL change_extra_writes: got %0d extra, want 0", obs_q.size() - rd_ptr); end
    rd_ptr = obs_q.size();
  endtask

  task automatic test_reset_mid();
    int  cyc, d0;
    wr_t e, o;
    d0 = done_pulses;
    pulse_start(8'd3, 8'd4, 8'd5);
    repeat (3) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    compared++; if ({valid, busy, done, error, addr, data, err_addr} !== '0) begin
      mismatched++;
      $display("[TB] FAIL midreset_outputs: got valid=%b busy=%b done=%b error=%b addr=%0d data=%0d err_addr=%0d, want all 0",
               valid, busy, done, error, addr, data, err_addr);
    end
    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    compared++; if (valid !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_idle: got valid=%b busy=%b, want 0/0", valid, busy); end
    compared++; if (done_pulses !== d0) begin mismatched++; $display("[TB] FAIL midreset_no_done: got %0d done pulses, want 0", done_pulses - d0); end
    rd_ptr = obs_q.size();
    exp_q.push_back({3'd0, 8'd6});
    exp_q.push_back({3'd1, 8'd7});
    exp_q.push_back({3'd2, 8'd8});
    pulse_start(8'd6, 8'd7, 8'd8);
    wait_done(100, cyc);
    compared++; if (cyc !== 10) begin mismatched++; $display("[TB] FAIL midreset_restart_latency: got %0d cycles, want 10", cyc); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (rd_ptr >= obs_q.size()) begin
        mismatched++; $display("[TB] FAIL midreset_write: got no handshake, want addr=%0d data=%0d", e.a, e.d);
      end else begin
        o = obs_q[rd_ptr]; rd_ptr++;
        if (o !== e) begin mismatched++; $display("[TB] FAIL midreset_write: got addr=%0d data=%0d, want addr=%0d data=%0d", o.a, o.d, e.a, e.d); end
      end
    end
    compared++; if ({regs[0], regs[1], regs[2]} !== {8'd6, 8'd7, 8'd8}) begin
      mismatched++; $display("[TB] FAIL midreset_regs: got %0d/%0d/%0d, want 6/7/8", regs[0], regs[1], regs[2]);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = M_NORMAL;
    t_red = '0; t_yellow = '0; t_green = '0;
    $display("[TB] starting tlc_cfg_master bench");
    test_reset();
    test_nominal();
    test_stall();
    test_stuck_ready();
    test_back_to_back();
    test_input_change();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
